bridge_deadtime_seq: RTL and testbench

BRIDGE_DEADTIME_SEQ -- requirements
Module: bridge_deadtime_seq

---
 rtl/bridge_pkg.sv | 49 ++++
 rtl/bridge_deadtime_seq_if.sv | 14 +
 rtl/bridge_deadtime_seq.sv | 148 ++++++++++++++
 tb/tb_bridge_deadtime_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared bridge definitions: mode encoding, FSM states and mode-to-gate patterns.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package bridge_pkg;

   localparam int MODE_W = 3;
   localparam int CNT_W  = 16;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF     = 3'd0,
      MODE_PLUS    = 3'd1,
      MODE_MINUS   = 3'd2,
      MODE_PAUSE_P = 3'd3,
      MODE_PAUSE_N = 3'd4
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ON,
      ST_DEAD
   } state_e;

   // One bit per bridge leg, bit 0 of each field drives leg 1.
   typedef struct packed {
      logic [3:0] top;
      logic [3:0] bot;
   } pat_t;

   localparam pat_t PAT_OFF     = '{top: 4'b0000, bot: 4'b0000};
   localparam pat_t PAT_PLUS    = '{top: 4'b0001, bot: 4'b0010};
   localparam pat_t PAT_MINUS   = '{top: 4'b0010, bot: 4'b0001};
   localparam pat_t PAT_PAUSE_P = '{top: 4'b0100, bot: 4'b1000};
   localparam pat_t PAT_PAUSE_N = '{top: 4'b1000, bot: 4'b0100};

   function automatic logic mode_legal(input logic [MODE_W-1:0] m);
      return m <= 3'd4;
   endfunction

   function automatic pat_t pat_of(input mode_e m);
      case (m)
         MODE_PLUS:    return PAT_PLUS;
         MODE_MINUS:   return PAT_MINUS;
         MODE_PAUSE_P: return PAT_PAUSE_P;
         MODE_PAUSE_N: return PAT_PAUSE_N;
         default:      return PAT_OFF;
      endcase
   endfunction

endpackage

// File: rtl/bridge_deadtime_seq_if.sv
// Mode-request handshake bundle between the command decoder and the bridge sequencer.
// Latency: n/a (wires only).
// Backpressure: request is taken on any cycle with req_valid and req_ready both high.
// Signals: req_valid (request present), req_mode (requested mode), req_ready (sequencer can take it).
interface bridge_deadtime_seq_if;
   import bridge_pkg::*;

   logic              req_valid;
   logic [MODE_W-1:0] req_mode;
   logic              req_ready;

   modport master (output req_valid, output req_mode, input  req_ready);
   modport slave  (input  req_valid, input  req_mode, output req_ready);
endinterface

// File: rtl/bridge_deadtime_seq.sv
// H-bridge gate sequencer: applies mode patterns with a min-on hold and an all-off dead gap between patterns.
// Latency: accepted request reaches the gates on the next clk edge; kill clears the gates on the next edge.
// Backpressure: req_ready low in DEAD, during the min-on hold, under kill and until the first edge after reset.
// Ports: clk, rstn (async active-low), req (slave handshake), kill (level, highest priority),
//        o_top/o_bot (registered gate drives), cur_mode, busy (in DEAD), err_mode (illegal-mode pulse).
module bridge_deadtime_seq
   import bridge_pkg::*;
#(
   parameter int DEADTIME_CYC = 50,
   parameter int MIN_ON_CYC   = 500
) (
   input  logic                        clk,
   input  logic                        rstn,
   bridge_deadtime_seq_if.slave        req,
   input  logic                        kill,
   output logic [4:1]                  o_top,
   output logic [4:1]                  o_bot,
   output logic [MODE_W-1:0]           cur_mode,
   output logic                        busy,
   output logic                        err_mode
);

   localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(MIN_ON_CYC - 1);
   localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEADTIME_CYC - 1);

   state_e            state_q, state_d;
   mode_e             cur_q, cur_d;
   mode_e             tgt_q, tgt_d;
   pat_t              pat_q, pat_d;
   logic [CNT_W-1:0]  on_cnt_q, on_cnt_d;
   logic [CNT_W-1:0]  dead_cnt_q, dead_cnt_d;
   logic              on_done_q, on_done_d;
   logic              err_q, err_d;
   logic              run_q;

   logic              accept;
   logic              req_legal;
   mode_e             req_m;

   assign req_legal = mode_legal(req.req_mode);
   assign req_m     = mode_e'(req.req_mode);

   // run_q keeps ready low until the first edge after reset release.
   // on_done_q lags the min-on counter reaching zero by one cycle, so a
   // pattern is held MIN_ON_CYC full cycles before a new request can land.
   assign req.req_ready = run_q && !kill &&
                          ((state_q == ST_IDLE) || ((state_q == ST_ON) && on_done_q));
   assign accept = req.req_valid && req.req_ready;

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      tgt_d      = tgt_q;
      pat_d      = pat_q;
      on_cnt_d   = (on_cnt_q   != '0) ? on_cnt_q   - 1'b1 : '0;
      dead_cnt_d = (dead_cnt_q != '0) ? dead_cnt_q - 1'b1 : '0;
      on_done_d  = (state_q == ST_ON) && (on_done_q || (on_cnt_q == '0));
      err_d      = 1'b0;

      if (kill) begin
         state_d    = ST_IDLE;
         cur_d      = MODE_OFF;
         tgt_d      = MODE_OFF;
         pat_d      = PAT_OFF;
         on_cnt_d   = '0;
         dead_cnt_d = '0;
         on_done_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (!req_legal) begin
                     err_d = 1'b1;
                  end else if (req_m != MODE_OFF) begin
                     state_d  = ST_ON;
                     cur_d    = req_m;
                     pat_d    = pat_of(req_m);
                     on_cnt_d = ON_LOAD;
                  end
               end
            end
            ST_ON: begin
               if (accept) begin
                  if (!req_legal) begin
                     err_d = 1'b1;
                  end else if (req_m != cur_q) begin
                     state_d    = ST_DEAD;
                     cur_d      = MODE_OFF;
                     tgt_d      = req_m;
                     pat_d      = PAT_OFF;
                     dead_cnt_d = DEAD_LOAD;
                     on_done_d  = 1'b0;
                  end
               end
            end
            ST_DEAD: begin
               if (dead_cnt_q == '0) begin
                  tgt_d = MODE_OFF;
                  if (tgt_q != MODE_OFF) begin
                     state_d  = ST_ON;
                     cur_d    = tgt_q;
                     pat_d    = pat_of(tgt_q);
                     on_cnt_d = ON_LOAD;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               cur_d   = MODE_OFF;
               pat_d   = PAT_OFF;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         cur_q      <= MODE_OFF;
         tgt_q      <= MODE_OFF;
         pat_q      <= PAT_OFF;
         on_cnt_q   <= '0;
         dead_cnt_q <= '0;
         on_done_q  <= 1'b0;
         err_q      <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         tgt_q      <= tgt_d;
         pat_q      <= pat_d;
         on_cnt_q   <= on_cnt_d;
         dead_cnt_q <= dead_cnt_d;
         on_done_q  <= on_done_d;
         err_q      <= err_d;
         run_q      <= 1'b1;
      end
   end

   assign o_top    = pat_q.top;
   assign o_bot    = pat_q.bot;
   assign cur_mode = cur_q;
   assign busy     = (state_q == ST_DEAD);
   assign err_mode = err_q;

endmodule

// File: tb/tb_bridge_deadtime_seq.sv
// Directed bench for bridge_deadtime_seq with DEADTIME_CYC=4, MIN_ON_CYC=8.
// Latency: n/a.
// Backpressure: n/a.
module tb_bridge_deadtime_seq;

   localparam int DT = 4;
   localparam int MO = 8;

   localparam logic [3:0] PT = 4'b0001, PB = 4'b0010;
   localparam logic [3:0] MT = 4'b0010, MB = 4'b0001;
   localparam logic [3:0] NT = 4'b1000, NB = 4'b0100;

   typedef struct {
      logic       vld;
      logic [2:0] mode;
      logic       kill;
      logic       rdy;
      logic [3:0] top;
      logic [3:0] bot;
      logic [2:0] cur;
      logic       busy;
      logic       err;
   } vec_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic       kill;
   logic [4:1] o_top;
   logic [4:1] o_bot;
   logic [2:0] cur_mode;
   logic       busy;
   logic       err_mode;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] prev_pat = 8'h00;
   vec_t       tbl[$];

   bridge_deadtime_seq_if req_if ();

   bridge_deadtime_seq #(.DEADTIME_CYC(DT), .MIN_ON_CYC(MO)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .req      (req_if),
      .kill     (kill),
      .o_top    (o_top),
      .o_bot    (o_bot),
      .cur_mode (cur_mode),
      .busy     (busy),
      .err_mode (err_mode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %04h want %04h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] outs();
      return 16'({o_top, o_bot, cur_mode, busy, err_mode});
   endfunction

   function automatic logic [15:0] pack(input logic [3:0] t, input logic [3:0] b,
                                        input logic [2:0] c, input logic bz, input logic e);
      return 16'({t, b, c, bz, e});
   endfunction

   // Advance one edge, then watch for shoot-through and direct pattern swaps.
   task automatic tick();
      logic [7:0] pat;
      @(posedge clk);
      #1;
      pat = {o_top, o_bot};
      chk("no_shoot_through", 16'(o_top & o_bot), 16'h0000);
      if (prev_pat != 8'h00 && pat != 8'h00)
         chk("no_direct_swap", 16'(pat), 16'(prev_pat));
      prev_pat = pat;
   endtask

   task automatic add(input logic v, input logic [2:0] m, input logic k, input logic r,
                      input logic [3:0] t, input logic [3:0] b, input logic [2:0] c,
                      input logic bz, input logic e);
      vec_t x;
      x.vld = v; x.mode = m; x.kill = k; x.rdy = r;
      x.top = t; x.bot = b; x.cur = c; x.busy = bz; x.err = e;
      tbl.push_back(x);
   endtask

   task automatic add_n(input int n, input logic v, input logic [2:0] m, input logic k,
                        input logic r, input logic [3:0] t, input logic [3:0] b,
                        input logic [2:0] c, input logic bz, input logic e);
      for (int j = 0; j < n; j++) add(v, m, k, r, t, b, c, bz, e);
   endtask

   initial begin
      // Row fields: vld, mode, kill | ready this cycle | top, bot, cur, busy, err after the edge.
      add  (1, 3'd0, 0, 1, 4'h0, 4'h0, 3'd0, 0, 0);   // OFF in IDLE: no-op
      add  (1, 3'd7, 0, 1, 4'h0, 4'h0, 3'd0, 0, 1);   // illegal in IDLE: err pulse
      add  (0, 3'd0, 0, 1, 4'h0, 4'h0, 3'd0, 0, 0);
      add  (1, 3'd1, 0, 1, PT,   PB,   3'd1, 0, 0);   // PLUS accepted
      add_n(8, 1, 3'd2, 0, 0, PT, PB, 3'd1, 0, 0);    // min-on hold, MINUS refused
      add  (1, 3'd1, 0, 1, PT,   PB,   3'd1, 0, 0);   // same mode: no-op
      add  (1, 3'd6, 0, 1, PT,   PB,   3'd1, 0, 1);   // illegal in ON: err, pattern kept
      add  (0, 3'd0, 0, 1, PT,   PB,   3'd1, 0, 0);   // no reload happened, still ready
      add  (1, 3'd2, 0, 1, 4'h0, 4'h0, 3'd0, 1, 0);   // MINUS accepted -> DEAD
      add_n(3, 1, 3'd1, 0, 0, 4'h0, 4'h0, 3'd0, 1, 0);
      add  (0, 3'd0, 0, 0, MT,   MB,   3'd2, 0, 0);   // MINUS applied after 4 off cycles
      add_n(8, 0, 3'd0, 0, 0, MT, MB, 3'd2, 0, 0);
      add  (1, 3'd3, 0, 1, 4'h0, 4'h0, 3'd0, 1, 0);   // PAUSE_P accepted -> DEAD
      add  (0, 3'd0, 0, 0, 4'h0, 4'h0, 3'd0, 1, 0);
      add  (0, 3'd0, 1, 0, 4'h0, 4'h0, 3'd0, 0, 0);   // kill mid-DEAD -> IDLE
      add_n(5, 0, 3'd0, 0, 1, 4'h0, 4'h0, 3'd0, 0, 0); // target never appears
      add  (1, 3'd1, 1, 0, 4'h0, 4'h0, 3'd0, 0, 0);   // kill blocks requests
      add  (0, 3'd0, 0, 1, 4'h0, 4'h0, 3'd0, 0, 0);
      add  (1, 3'd4, 0, 1, NT,   NB,   3'd4, 0, 0);   // PAUSE_N accepted
      add_n(8, 0, 3'd0, 0, 0, NT, NB, 3'd4, 0, 0);
      add  (1, 3'd0, 0, 1, 4'h0, 4'h0, 3'd0, 1, 0);   // OFF in ON -> DEAD
      add_n(3, 0, 3'd0, 0, 0, 4'h0, 4'h0, 3'd0, 1, 0);
      add  (0, 3'd0, 0, 0, 4'h0, 4'h0, 3'd0, 0, 0);   // off target -> IDLE
      add  (0, 3'd0, 0, 1, 4'h0, 4'h0, 3'd0, 0, 0);
      add  (1, 3'd1, 0, 1, PT,   PB,   3'd1, 0, 0);
      add  (0, 3'd0, 1, 0, 4'h0, 4'h0, 3'd0, 0, 0);   // kill mid-ON
      add  (0, 3'd0, 0, 1, 4'h0, 4'h0, 3'd0, 0, 0);

      rstn = 1'b0;
      kill = 1'b0;
      req_if.req_valid = 1'b0;
      req_if.req_mode  = 3'd0;
      tick();
      tick();
      chk("reset_outputs", outs(), pack(4'h0, 4'h0, 3'd0, 1'b0, 1'b0));
      chk("reset_ready", 16'(req_if.req_ready), 16'h0000);

      rstn = 1'b1;
      #1;
      chk("ready_before_first_edge", 16'(req_if.req_ready), 16'h0000);
      tick();
      chk("ready_after_first_edge", 16'(req_if.req_ready), 16'h0001);

      for (int i = 0; i < tbl.size(); i++) begin
         req_if.req_valid = tbl[i].vld;
         req_if.req_mode  = tbl[i].mode;
         kill             = tbl[i].kill;
         #1;
         chk($sformatf("row%0d_ready", i), 16'(req_if.req_ready), 16'(tbl[i].rdy));
         tick();
         chk($sformatf("row%0d_outputs", i), outs(),
             pack(tbl[i].top, tbl[i].bot, tbl[i].cur, tbl[i].busy, tbl[i].err));
      end

      // Reset asserted mid-ON clears gates without waiting for an edge.
      req_if.req_valid = 1'b1;
      req_if.req_mode  = 3'd1;
      tick();
      chk("rst_seq_on", outs(), pack(PT, PB, 3'd1, 1'b0, 1'b0));
      req_if.req_valid = 1'b0;
      tick();
      tick();
      rstn = 1'b0;
      req_if.req_valid = 1'b1;
      req_if.req_mode  = 3'd1;
      #1;
      chk("rst_async_outputs", outs(), pack(4'h0, 4'h0, 3'd0, 1'b0, 1'b0));
      chk("rst_async_ready", 16'(req_if.req_ready), 16'h0000);
      tick();
      chk("rst_held_outputs", outs(), pack(4'h0, 4'h0, 3'd0, 1'b0, 1'b0));
      rstn = 1'b1;
      #1;
      chk("rel_ready_pre_edge", 16'(req_if.req_ready), 16'h0000);
      tick();
      chk("rel_edge1_ready", 16'(req_if.req_ready), 16'h0001);
      chk("rel_edge1_outputs", outs(), pack(4'h0, 4'h0, 3'd0, 1'b0, 1'b0));
      tick();
      chk("rel_edge2_plus", outs(), pack(PT, PB, 3'd1, 1'b0, 1'b0));
      req_if.req_valid = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
